mdu_hilo: RTL and testbench

//   Iterative multiply/divide unit that owns the HI/LO architectural registers for the MIPS pipeline.

---
 rtl/mdu_hilo.sv | 155 +++++++++++++++
 tb/tb_mdu_hilo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add MUL, restoring DIV).
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module mdu_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      acc, acc_step;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_lo, neg_hi;

  logic               op_mul, op_div, op_mthi, op_mtlo, sgn;
  logic               accept, b_zero, iter_go;
  logic [WIDTH-1:0]   a_abs, b_abs;

  assign op_mul  = (op[2:1] == 2'b00);
  assign op_div  = (op[2:1] == 2'b01);
  assign op_mthi = (op == 3'b100);
  assign op_mtlo = (op == 3'b101);
  assign sgn     = ~op[0];
  assign accept  = (state == IDLE) && start && !flush;
  assign b_zero  = (b == '0);
  assign a_abs   = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (sgn && b[WIDTH-1]) ? -b : b;
  assign busy    = (state != IDLE);

`ifdef MDU_FAST_MUL_EN
  logic             fast_go;
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  assign iter_go   = accept && op_div && !b_zero;
  assign fast_go   = accept && op_mul;
  assign ext_a     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign ext_b     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign fast_prod = ext_a * ext_b;
`else
  assign iter_go   = accept && (op_mul || (op_div && !b_zero));
`endif

  // One iteration: shift-add on the low multiplier bit, or restoring subtract-shift.
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             ge;
  always_comb begin
    mul_sum  = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, opb});
    acc_step = '0;
    if (is_div)
      acc_step = {(ge ? rem_sh - {1'b0, opb} : rem_sh), acc[WIDTH-2:0], ge};
    else
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iter_go) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opb         <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && op_mthi) hi <= a;
            if (accept && op_mtlo) lo <= a;
            if (accept && op_div && b_zero) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end
            if (iter_go) begin
              acc    <= {{(WIDTH+1){1'b0}}, a_abs};
              opb    <= b_abs;
              is_div <= op_div;
              neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= sgn && a[WIDTH-1];
              cnt    <= '0;
            end
`ifdef MDU_FAST_MUL_EN
            if (fast_go) begin
              {hi, lo} <= fast_prod;
              done     <= 1'b1;
            end
`endif
          end
          RUN: begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
          end
          SIGN: begin
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed + scoreboard bench for mdu_hilo (WIDTH=32); builds with or without MDU_FAST_MUL_EN.
module tb_mdu_hilo;

  localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} computed with 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] h, input logic [31:0] l);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r  = '0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: begin
        if (y == 0) return {1'b1, h, l};
        r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) return {1'b1, h, l};
        r = {32'(ux % uy), 32'(ux / uy)};
      end
      default: r = {h, l};
    endcase
    return {1'b0, r};
  endfunction

  // Issue one MUL/DIV, wait for done, compare against the scoreboard; returns in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int lat);
    logic [64:0] e;
    int k;
    sb_q.push_back(model(o, x, y, m_hi, m_lo));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    check("busy_after_start", {63'b0, busy}, {63'b0, lat != 0});
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    e = sb_q.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL done_timeout: observed no done after %0d cycles, expected done", k);
    end else begin
      check("latency", 64'(k), 64'(lat));
      check("hi", {32'b0, hi}, {32'b0, e[63:32]});
      check("lo", {32'b0, lo}, {32'b0, e[31:0]});
      check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e[64]});
      check("busy_at_done", {63'b0, busy}, 64'b0);
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'd4) m_hi = x; else m_lo = x;
    check("mt_hi", {32'b0, hi}, {32'b0, m_hi});
    check("mt_lo", {32'b0, lo}, {32'b0, m_lo});
    check("mt_done", {62'b0, done, busy}, 64'b0);
  endtask

  initial begin
    int seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'b0);
    check("reset_flags", {61'b0, busy, done, div_by_zero}, 64'b0);
    rst = 1'b0;

    // Multiply: signed and unsigned with the same operands
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, MUL_LAT);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, MUL_LAT);
    check("multu_const", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    @(posedge clk); #1;
    check("done_one_cycle", {62'b0, done, div_by_zero}, 64'b0);

    // Divide, including the MIN_NEG / -1 overflow case
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7, DIV_LAT);
    check("divu_const", {hi, lo}, 64'h0000_0002_0000_000E);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // Divide by zero keeps hi/lo
    mt(3'd4, 32'hA);
    mt(3'd5, 32'hB);
    run_op(3'd2, 32'd5, 32'd0, 0);
    check("dz_const", {hi, lo}, 64'h0000_000A_0000_000B);

    // MTHI / MTLO
    mt(3'd4, 32'h1234_5678);
    mt(3'd5, 32'hCAFE_F00D);

    // NOP op code leaves everything alone
    op = 3'd7; a = 32'h5555_5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nop_hilo", {hi, lo}, {m_hi, m_lo});
    check("nop_flags", {62'b0, busy, done}, 64'b0);

    // flush beats start: MTHI and DIV both dropped
    op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    op = 3'd2; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});
    check("flush_start_busy", {63'b0, busy}, 64'b0);
    @(posedge clk); #1;
    check("flush_start_done", {63'b0, done}, 64'b0);

    // DIVU in flight; MULT start ignored; flush aborts
    op = 3'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_while_ignored", {63'b0, busy}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("flush_no_done", 64'(seen), 64'b0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    run_op(3'd3, 32'd1000, 32'd3, DIV_LAT);
    check("after_flush_const", {hi, lo}, 64'h0000_0001_0000_014D);

    // Random back-to-back operations (start issued in the done cycle)
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)) ^ {32{rx[0]}};
      if (ry == 0) ry = 32'd1;
      run_op(ro, rx, ry, (ro < 3'd2) ? MUL_LAT : DIV_LAT);
    end

    // Async reset mid-operation
`ifdef MDU_FAST_MUL_EN
    op = 3'd3; a = 32'd77; b = 32'd5;
`else
    op = 3'd0; a = 32'd6; b = 32'd7;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_hilo", {hi, lo}, 64'b0);
    check("rst_flags", {61'b0, busy, done, div_by_zero}, 64'b0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 32'd6, 32'd7, MUL_LAT);
    check("mult_6x7", {hi, lo}, 64'd42);

    check("sb_empty", 64'(sb_q.size()), 64'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
